lights_sequencer: RTL and testbench



---
 rtl/lights_pkg.sv | 14 +
 rtl/lights_sequencer_hold_counter.sv | 38 +++
 rtl/lights_sequencer.sv | 103 ++++++++++
 tb/tb_lights_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/lights_pkg.sv
// Shared types and default sizes for the start-light chain
// (tick generator, sequencer, reaction timer).
package lights_pkg;

  localparam int LP_NUM_LIGHTS = 10;
  localparam int LP_HOLD_W     = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/lights_sequencer_hold_counter.sv
// Loadable down-counter for the all-lit hold phase.
// Saturates at zero; zero flag is taken from the register.
module hold_counter
  import lights_pkg::*;
#(
  parameter int HOLD_W = LP_HOLD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lights_sequencer.sv
// Start-light sequencer: fills lights one per tick, holds,
// then drops them all and pulses lights_off.
module lights_sequencer
  import lights_pkg::*;
#(
  parameter int NUM_LIGHTS = LP_NUM_LIGHTS,
  parameter int HOLD_W     = LP_HOLD_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  trigger,
  input  logic [HOLD_W-1:0]     hold_ticks,
  output logic [NUM_LIGHTS-1:0] ledr,
  output logic                  lights_off,
  output logic                  busy
);

  state_e                state_q;
  state_e                state_d;
  logic [NUM_LIGHTS-1:0] ledr_q;
  logic [NUM_LIGHTS-1:0] ledr_d;
  logic                  lights_off_q;
  logic                  lights_off_d;
  logic [HOLD_W-1:0]     hold_reg_q;
  logic [HOLD_W-1:0]     hold_reg_d;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  cnt_zero;

  hold_counter #(
    .HOLD_W(HOLD_W)
  ) u_hold_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .load_val(hold_reg_q),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    ledr_d       = ledr_q;
    lights_off_d = 1'b0;
    hold_reg_d   = hold_reg_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ledr_d = '0;
        // A tick coinciding with the accept is deliberately dropped.
        if (trigger) begin
          state_d    = ST_FILL;
          hold_reg_d = hold_ticks;
        end
      end
      ST_FILL: begin
        if (tick) begin
          ledr_d = {ledr_q[NUM_LIGHTS-2:0], 1'b1};
          if (&ledr_d) begin
            state_d  = ST_HOLD;
            cnt_load = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          if (cnt_zero) begin
            ledr_d       = '0;
            lights_off_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ledr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ledr_q       <= '0;
      lights_off_q <= 1'b0;
      hold_reg_q   <= '0;
    end else begin
      state_q      <= state_d;
      ledr_q       <= ledr_d;
      lights_off_q <= lights_off_d;
      hold_reg_q   <= hold_reg_d;
    end
  end

  assign ledr       = ledr_q;
  assign lights_off = lights_off_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lights_sequencer.sv
// Randomized scoreboard bench for lights_sequencer.
// Expected outputs come from a tick-counting model of a sequence.
module tb_lights_sequencer;

  localparam int N  = 10;
  localparam int HW = 14;

  typedef struct {
    logic [N-1:0] ledr;
    logic         busy;
    logic         lo;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          tick;
  logic          trigger;
  logic [HW-1:0] hold_ticks;
  logic [N-1:0]  ledr;
  logic          lights_off;
  logic          busy;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  int   n_cyc;

  // model: a sequence is a count of ticks since accept
  bit m_active;
  int m_ticks;
  int m_hold;
  bit m_lo;

  lights_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .trigger   (trigger),
    .hold_ticks(hold_ticks),
    .ledr      (ledr),
    .lights_off(lights_off),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model_out();
    exp_t e;
    int   lit;
    lit    = (m_ticks < N) ? m_ticks : N;
    e.ledr = m_active ? N'((1 << lit) - 1) : '0;
    e.busy = m_active;
    e.lo   = m_lo;
    return e;
  endfunction

  task automatic cyc(input bit r, input bit t,
                     input bit k, input logic [HW-1:0] h);
    @(negedge clk);
    rst_n      = ~r;
    trigger    = t;
    tick       = k;
    hold_ticks = h;
    n_cyc++;
    m_lo = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_ticks  = 0;
    end else if (!m_active) begin
      if (t) begin
        m_active = 1'b1;
        m_ticks  = 0;
        m_hold   = int'(h);
      end
    end else if (k) begin
      m_ticks++;
      if (m_ticks == N + m_hold + 1) begin
        m_active = 1'b0;
        m_lo     = 1'b1;
      end
    end
    exp_q.push_back(model_out());
  endtask

  // mode 0: trigger pulse; 1: random trigger/hold churn; 2: trigger held
  task automatic run_seq(input int hold, input int period,
                         input int mode);
    int            c;
    bit            t;
    bit            k;
    logic [HW-1:0] h;
    c = 0;
    h = HW'(hold);
    do begin
      t = (c == 0) || (mode == 2) ||
          ((mode == 1) && ($urandom_range(0, 3) == 0));
      k = ((c % period) == 0);
      if ((mode == 1) && (c > 0)) h = HW'($urandom);
      cyc(1'b0, t, k, h);
      c++;
    end while (m_active && (c < 40000));
    if (m_active) begin
      n_bad++;
      $display("FAIL seq_budget: still busy after %0d cycles, need done", c);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ((ledr !== e.ledr) || (busy !== e.busy) ||
            (lights_off !== e.lo)) begin
          n_bad++;
          $display("FAIL outputs t=%0t: ledr=%h busy=%b lo=%b, need ledr=%h busy=%b lo=%b",
                   $time, ledr, busy, lights_off, e.ledr, e.busy, e.lo);
        end
      end
    end
  end

  initial begin : driver
    n_cmp    = 0;
    n_bad    = 0;
    n_cyc    = 0;
    m_active = 1'b0;
    m_ticks  = 0;
    m_hold   = 0;
    m_lo     = 1'b0;
    rst_n      = 1'b0;
    tick       = 1'b0;
    trigger    = 1'b0;
    hold_ticks = '0;

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, HW'($urandom));
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, i[0], HW'($urandom));

    run_seq(3, 5, 0);
    cyc(1'b0, 1'b0, 1'b1, '0);
    run_seq(0, 3, 0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    run_seq(16383, 1, 0);
    cyc(1'b0, 1'b0, 1'b1, '0);
    run_seq(2, 1, 0);
    run_seq(1, 2, 2);
    run_seq(4, 2, 2);
    cyc(1'b0, 1'b0, 1'b0, '0);
    run_seq(5, 2, 1);
    cyc(1'b0, 1'b0, 1'b0, '0);
    run_seq(2, 3, 1);

    cyc(1'b0, 1'b1, 1'b0, HW'(20));
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b1, HW'(7));
    cyc(1'b1, 1'b0, 1'b1, HW'(7));
    cyc(1'b0, 1'b0, 1'b1, HW'(7));
    run_seq(2, 3, 0);

    repeat (8) begin
      run_seq($urandom_range(0, 6), $urandom_range(1, 4),
              $urandom_range(0, 1));
      repeat ($urandom_range(0, 3))
        cyc(1'b0, 1'b0, 1'($urandom), HW'($urandom));
    end

    repeat (4) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d pending, need 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
